// File: rtl/stepper_sequencer.sv
// stepper_sequencer
// Full-step driver for the four claw stepper coils on the JB pmod pins.
// It accepts one move command (direction plus step count) over a
// valid/ready handshake and paces the steps with a fixed clock divider.
// A move ends early on the end-stop in the direction of travel, or on abort.
//
// Ports
//   clock       system clock; all logic runs on its rising edge
//   reset       asynchronous, active-low reset
//   cmd_valid   a move command is present
//   cmd_ready   a command can be accepted (high only while idle)
//   cmd_dir     1 = forward (+), 0 = reverse (-)
//   cmd_steps   number of steps to move
//   abort       terminate the current move
//   limit_lo    reverse end-stop (already synchronised)
//   limit_hi    forward end-stop (already synchronised)
//   hold_en     keep the coils energised while idle
//   coils       {JB1,JB2,JB3,JB4} drive pattern
//   busy        a move is in progress
//   done        one-cycle pulse at the end of every accepted move
//   stalled     the last move ended on an end-stop
//   steps_left  steps remaining in the current or last move
//   position    signed absolute step count (wraps)
module stepper_sequencer #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  input  logic             limit_lo,
  input  logic             limit_hi,
  input  logic             hold_en,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic             stalled,
  output logic [CNT_W-1:0] steps_left,
  output logic [31:0]      position
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [DIV_W-1:0] div;
  logic             dir;

  logic tick;
  logic limit_hit;
  logic [3:0] phase_pattern;

  assign tick      = (div == DIV_LAST);
  // Only the end-stop in the direction of travel can stop a move.
  assign limit_hit = dir ? limit_hi : limit_lo;
  assign cmd_ready = (state == IDLE);

  always_comb begin
    phase_pattern = 4'b1100;
    case (phase)
      2'd0: phase_pattern = 4'b1100;
      2'd1: phase_pattern = 4'b0110;
      2'd2: phase_pattern = 4'b0011;
      2'd3: phase_pattern = 4'b1001;
      default: phase_pattern = 4'b1100;
    endcase
  end

  // Idle coils follow hold_en directly, so the reset value of phase already
  // gives the right pattern while reset is held.
  assign coils = ((state == RUN) || hold_en) ? phase_pattern : 4'b0000;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= 2'd0;
      div        <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stalled    <= 1'b0;
      steps_left <= '0;
      position   <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            stalled    <= 1'b0;
            steps_left <= cmd_steps;
            if (cmd_steps == '0) begin
              // Empty move: acknowledge it without ever going busy.
              done <= 1'b1;
            end else begin
              dir   <= cmd_dir;
              div   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (abort) begin
            // Abort beats a coincident tick: the pending step is dropped.
            div   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (tick) begin
            div <= '0;
            if (limit_hit) begin
              stalled <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              phase      <= dir ? phase + 2'd1 : phase - 2'd1;
              position   <= dir ? position + 32'd1 : position - 32'd1;
              steps_left <= steps_left - CNT_W'(1);
              if (steps_left == CNT_W'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
module tb_stepper_sequencer;

  localparam int D = 4;
  localparam int W = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [W-1:0]  cmd_steps = '0;
  logic          abort = 1'b0;
  logic          limit_lo = 1'b0;
  logic          limit_hi = 1'b0;
  logic          hold_en = 1'b1;
  logic [3:0]    coils;
  logic          busy;
  logic          done;
  logic          stalled;
  logic [W-1:0]  steps_left;
  logic [31:0]   position;

  int checks = 0;
  int errors = 0;

  // Reference state: where the motor should be after everything so far.
  int m_phase = 0;
  int m_pos   = 0;

  stepper_sequencer #(.CLK_DIV(D), .CNT_W(W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .abort(abort), .limit_lo(limit_lo), .limit_hi(limit_hi),
    .hold_en(hold_en), .coils(coils), .busy(busy), .done(done),
    .stalled(stalled), .steps_left(steps_left), .position(position)
  );

  always #5 clock = ~clock;

  // Full-step coil table, indexed by any integer phase.
  function automatic logic [3:0] pat(input int p);
    case (((p % 4) + 4) % 4)
      0: return 4'b1100;
      1: return 4'b0110;
      2: return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic tick_cycle();
    @(posedge clock);
    #1;
  endtask

  // Present a command for exactly one accept edge; returns 1 ns after it.
  task automatic accept(input logic d, input int n);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = W'(n);
    tick_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    hold_en = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || stalled !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b stalled=%b expected 0 0 0", busy, done, stalled); end
    checks++; if (steps_left !== '0 || position !== 32'd0) begin errors++; $display("FAIL reset_counts: got steps_left=%0d position=%0d expected 0 0", steps_left, position); end
    checks++; if (coils !== 4'b1100 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_coils: got coils=%b ready=%b expected 1100 1", coils, cmd_ready); end
    hold_en = 1'b0;
    #1;
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL reset_nohold: got coils=%b expected 0000", coils); end
    #5 reset = 1'b1;
    hold_en = 1'b1;
    tick_cycle();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", cmd_ready, busy); end
    $display("test_reset done");
  endtask

  task automatic test_fwd_move();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    int k;
    hold_en = 1'b1;
    accept(1'b1, 3);
    if (busy) busy_cnt++;
    for (int c = 1; c <= 16; c++) begin
      tick_cycle();
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      k = (c / D > 3) ? 3 : c / D;
      checks++; if (coils !== pat(m_phase + k)) begin errors++; $display("FAIL fwd_coils c=%0d: got %b expected %b", c, coils, pat(m_phase + k)); end
    end
    checks++; if (busy_cnt != 3 * D) begin errors++; $display("FAIL fwd_busy_len: got %0d expected %0d", busy_cnt, 3 * D); end
    checks++; if (done_cnt != 1 || done_at != 3 * D) begin errors++; $display("FAIL fwd_done: got count=%0d at=%0d expected 1 at %0d", done_cnt, done_at, 3 * D); end
    checks++; if (position !== 32'(m_pos + 3) || steps_left !== '0) begin errors++; $display("FAIL fwd_final: got pos=%0d left=%0d expected %0d 0", position, steps_left, m_pos + 3); end
    m_phase += 3; m_pos += 3;
    $display("test_fwd_move done pos=%0d", position);
  endtask

  task automatic test_rev_and_hold();
    accept(1'b0, 2);
    for (int c = 1; c <= 2 * D; c++) begin
      tick_cycle();
      if (c % D == 0) begin
        checks++; if (coils !== pat(m_phase - c / D)) begin errors++; $display("FAIL rev_coils c=%0d: got %b expected %b", c, coils, pat(m_phase - c / D)); end
      end
    end
    checks++; if (done !== 1'b1 || position !== 32'(m_pos - 2)) begin errors++; $display("FAIL rev_end: got done=%b pos=%0d expected 1 %0d", done, position, m_pos - 2); end
    m_phase -= 2; m_pos -= 2;
    hold_en = 1'b0;
    #1;
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL rev_nohold: got coils=%b expected 0000", coils); end
    hold_en = 1'b1;
    $display("test_rev_and_hold done pos=%0d", position);
  endtask

  task automatic test_zero_steps();
    accept(1'b1, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_ack: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (coils !== pat(m_phase) || position !== 32'(m_pos)) begin errors++; $display("FAIL zero_hold: got coils=%b pos=%0d expected %b %0d", coils, position, pat(m_phase), m_pos); end
    tick_cycle();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    $display("test_zero_steps done");
  endtask

  task automatic test_limit();
    int done_at = -1;
    accept(1'b1, 10);
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      tick_cycle();
      if (c == 4 * D) limit_hi = 1'b1;
      if (done) done_at = c;
    end
    checks++; if (done_at != 5 * D) begin errors++; $display("FAIL limit_done_at: got %0d expected %0d", done_at, 5 * D); end
    checks++; if (stalled !== 1'b1 || steps_left !== W'(6) || position !== 32'(m_pos + 4)) begin errors++; $display("FAIL limit_state: got stalled=%b left=%0d pos=%0d expected 1 6 %0d", stalled, steps_left, position, m_pos + 4); end
    m_phase += 4; m_pos += 4;
    accept(1'b0, 2);
    checks++; if (stalled !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL limit_clear: got stalled=%b busy=%b expected 0 1", stalled, busy); end
    repeat (2 * D) tick_cycle();
    checks++; if (done !== 1'b1 || position !== 32'(m_pos - 2) || stalled !== 1'b0) begin errors++; $display("FAIL limit_reverse: got done=%b pos=%0d stalled=%b expected 1 %0d 0", done, position, stalled, m_pos - 2); end
    m_phase -= 2; m_pos -= 2;
    limit_hi = 1'b0;
    $display("test_limit done pos=%0d", position);
  endtask

  task automatic test_abort();
    accept(1'b1, 5);
    cmd_valid = 1'b1;
    cmd_steps = W'(7);
    for (int c = 1; c <= 3 * D; c++) begin
      if (c == 3 * D) abort = 1'b1;
      tick_cycle();
      if (c < 3 * D) begin
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || steps_left !== W'(5 - c / D)) begin errors++; $display("FAIL abort_run c=%0d: got busy=%b ready=%b left=%0d expected 1 0 %0d", c, busy, cmd_ready, steps_left, 5 - c / D); end
      end
    end
    abort = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || stalled !== 1'b0) begin errors++; $display("FAIL abort_end: got done=%b busy=%b stalled=%b expected 1 0 0", done, busy, stalled); end
    checks++; if (steps_left !== W'(3) || position !== 32'(m_pos + 2)) begin errors++; $display("FAIL abort_count: got left=%0d pos=%0d expected 3 %0d", steps_left, position, m_pos + 2); end
    m_phase += 2; m_pos += 2;
    tick_cycle();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || steps_left !== W'(7)) begin errors++; $display("FAIL abort_held_cmd: got busy=%b left=%0d expected 1 7", busy, steps_left); end
    abort = 1'b1;
    tick_cycle();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || position !== 32'(m_pos)) begin errors++; $display("FAIL abort_second: got done=%b pos=%0d expected 1 %0d", done, position, m_pos); end
    $display("test_abort done pos=%0d", position);
  endtask

  task automatic test_reset_mid_move();
    hold_en = 1'b1;
    accept(1'b1, 5);
    repeat (D + 2) tick_cycle();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || position !== 32'd0 || steps_left !== '0) begin errors++; $display("FAIL rst_mid_state: got busy=%b done=%b pos=%0d left=%0d expected 0 0 0 0", busy, done, position, steps_left); end
    checks++; if (coils !== 4'b1100 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_coils: got coils=%b ready=%b expected 1100 1", coils, cmd_ready); end
    #2 reset = 1'b1;
    tick_cycle();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || position !== 32'd0) begin errors++; $display("FAIL rst_mid_release: got ready=%b busy=%b pos=%0d expected 1 0 0", cmd_ready, busy, position); end
    m_phase = 0; m_pos = 0;
    $display("test_reset_mid_move done");
  endtask

  // Random moves. Each move is described by when it ends (end_c cycles after
  // the accept edge) and how many steps it actually took; every sample in
  // between follows from plain arithmetic on those numbers.
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic d;
      int n, mode, s, a, end_c, taken, left_end, k, e_pos;
      logic st_end, opp;
      logic [3:0] e_coils;
      d    = 1'($urandom % 2);
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      opp  = 1'($urandom % 2);
      hold_en = 1'($urandom % 2);
      s = $urandom_range(0, n - 1);
      a = $urandom_range(1, n * D);
      case (mode)
        0: begin end_c = n * D;       taken = n;           st_end = 1'b0; end
        1: begin end_c = (s + 1) * D; taken = s;           st_end = 1'b1; end
        default: begin end_c = a;     taken = (a - 1) / D; st_end = 1'b0; end
      endcase
      left_end = n - taken;
      // An end-stop on the side we are moving away from must not matter.
      if (d) limit_lo = opp; else limit_hi = opp;
      accept(d, n);
      for (int c = 1; c <= end_c; c++) begin
        if (mode == 1 && c > s * D) begin
          if (d) limit_hi = 1'b1; else limit_lo = 1'b1;
        end
        abort = (mode == 2 && c == a);
        tick_cycle();
        k = (c < end_c) ? c / D : taken;
        e_pos = d ? m_pos + k : m_pos - k;
        e_coils = ((c < end_c) || hold_en) ? pat(d ? m_phase + k : m_phase - k) : 4'b0000;
        checks++;
        if (busy !== (c < end_c) || done !== (c == end_c) || cmd_ready !== (c >= end_c) ||
            position !== 32'(e_pos) || coils !== e_coils ||
            steps_left !== W'((c < end_c) ? n - k : left_end) ||
            stalled !== ((c == end_c) ? st_end : 1'b0)) begin
          errors++;
          $display("FAIL rand it=%0d c=%0d: got busy=%b done=%b pos=%0d coils=%b left=%0d st=%b expected busy=%b done=%b pos=%0d coils=%b left=%0d st=%b",
                   it, c, busy, done, position, coils, steps_left, stalled,
                   c < end_c, c == end_c, e_pos, e_coils, (c < end_c) ? n - k : left_end, (c == end_c) ? st_end : 1'b0);
        end
      end
      abort = 1'b0; limit_lo = 1'b0; limit_hi = 1'b0;
      tick_cycle();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_after it=%0d: got done=%b busy=%b expected 0 0", it, done, busy); end
      m_pos   = d ? m_pos + taken : m_pos - taken;
      m_phase = d ? m_phase + taken : m_phase - taken;
      $display("rand move %0d: dir=%0d n=%0d mode=%0d taken=%0d pos=%0d", it, d, n, mode, taken, position);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_move();
    test_rev_and_hold();
    test_zero_steps();
    test_limit();
    test_abort();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
Drives the four claw stepper-motor coil outputs (JB1..JB4) from move commands issued by the processor or a front-panel controller. It accepts a direction and step count over a valid/ready handshake, paces steps with a programmable clock divider, and stops on limit switches or abort. It reports busy, done, remaining steps and absolute position. It sits between the CPU's memory-mapped I/O and the JB pmod pins, replacing free-running motor drive.

Parameters:
CLK_DIV, 100000, clock cycles per step (1 kHz at 100 MHz); must be >= 2
CNT_W, 16, width of step-count fields

Ports:
clock  in  1  system clock (100 MHz), all logic on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  move command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_dir  in  1  1 = forward (+), 0 = reverse (-)
cmd_steps  in  CNT_W  number of steps to move
abort  in  1  terminate current move
limit_lo  in  1  reverse end-stop active (synchronised externally)
limit_hi  in  1  forward end-stop active
hold_en  in  1  1 = energise coils while idle; 0 = coils off while idle
coils  out  4  {JB1,JB2,JB3,JB4} drive pattern
busy  out  1  move in progress
done  out  1  one-cycle pulse at the end of any accepted move
stalled  out  1  last move ended on a limit switch; cleared on next accept
steps_left  out  CNT_W  steps remaining in the current or last move
position  out  32  signed absolute step count; wraps two's-complement

Behaviour:
- Reset (async, reset=0): state=IDLE, phase=0, div counter=0. Outputs: busy=0, done=0, stalled=0, steps_left=0, position=0. cmd_ready=1 once state is IDLE. coils = hold_en ? 4'b1100 : 4'b0000.
- Phase table (two-phase full step): 0=1100, 1=0110, 2=0011, 3=1001.
- coils = phase pattern while busy; while IDLE, phase pattern if hold_en else 0000. Phase is retained across moves.
- IDLE: cmd_ready=1; abort is ignored.
  - On cmd_valid&&cmd_ready with cmd_steps==0: done=1 next cycle, stalled cleared, no state change. busy stays 0.
  - On cmd_valid&&cmd_ready with cmd_steps!=0: latch dir, steps_left=cmd_steps, div=0, stalled=0, busy=1. Go to RUN.
- RUN: cmd_ready=0; cmd_valid is ignored. div increments each cycle.
  - A tick occurs on the cycle div==CLK_DIV-1; div then returns to 0.
  - On a tick, phase = phase+1 mod 4 (fwd) or phase-1 mod 4 (rev); position +/-1; steps_left-1.
  - If steps_left reaches 0 on that tick: IDLE, busy=0, done=1 for one cycle.
  - The first step lands CLK_DIV cycles after the accept edge. An N-step move has busy high for exactly N*CLK_DIV cycles.
- Limits are sampled only on tick cycles. If (dir=1 && limit_hi) or (dir=0 && limit_lo): the step is suppressed (no phase, position or steps_left change), stalled=1, done pulse, go to IDLE. A limit in the non-moving direction is ignored.
- Abort in RUN: go to IDLE the next edge with a done pulse. steps_left keeps the remaining count and stalled=0. If abort coincides with a tick, abort wins and no step is taken.
- Priority within one tick cycle: abort > limit > step.
- steps_left and position hold after a move ends until the next accept or reset.
- Reset asserted mid-move: all state clears immediately, with no clock edge needed. No done pulse.

Test Plan:
1. CLK_DIV=4. Reset, hold_en=1, cmd_dir=1, cmd_steps=3 -> coils 1100 -> 0110 (4 cycles after accept) -> 0011 (8) -> 1001 (12). done pulses on cycle 12 for exactly one cycle. position=3, steps_left=0, busy high 12 cycles.
2. From test 1 state, cmd_dir=0, cmd_steps=2 -> coils 0011 then 0110, position=1. Then hold_en=0 -> coils=0000 in IDLE.
3. cmd_steps=0 -> done one cycle after accept. busy never asserts, coils and position unchanged.
4. cmd_dir=1, cmd_steps=10; raise limit_hi after the 4th step -> next tick suppressed: stalled=1, position +4, steps_left=6, done pulse. Then limit_hi=1, cmd_dir=0, steps=2 -> moves normally, stalled cleared.
5. Abort on the same cycle as a tick in a 5-step move after 2 steps -> no third step. steps_left=3, done pulse, stalled=0. cmd_valid held high during RUN is not accepted until IDLE.
6. Drop reset mid-move with no clock -> busy=0, position=0, steps_left=0, coils reflect phase 0 / hold_en immediately. Release reset -> cmd_ready=1.
